// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage: sequential ROM fetch, prefetch FIFO with PC tags,
// valid/ready handoff to decode, branch redirect flush and halt.
module cpu_fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic [ADDR_W-1:0]  fetch_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic               inflight;
    logic [ADDR_W-1:0]  inflight_pc;
    logic [CW:0]        occupancy;
    logic               push, pop;

    // Credit counts the outstanding ROM read so a full FIFO can never be overrun.
    assign occupancy   = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign mem_req     = !reset && !halt && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    assign mem_addr    = fetch_pc;
    assign instr_valid = (count != '0);
    assign instr       = instr_mem[rd_ptr];
    assign instr_pc    = pc_mem[rd_ptr];
    assign push        = inflight && !redirect_valid;
    assign pop         = instr_valid && instr_ready && !redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (redirect_valid) begin
            // Flush everything; the response due next cycle belongs to the old path.
            fetch_pc <= redirect_pc;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight    <= mem_req;
            inflight_pc <= fetch_pc;
            if (mem_req)
                fetch_pc <= fetch_pc + 1'b1;
            if (push) begin
                instr_mem[wr_ptr] <= mem_rdata;
                pc_mem[wr_ptr]    <= inflight_pc;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Random + directed bench for cpu_fetch_unit against a queue-based stream model.
module tb_cpu_fetch_unit;
    logic        clk = 1'b0;
    logic        reset, mem_req, instr_valid, instr_ready, redirect_valid, halt;
    logic [7:0]  mem_addr, instr_pc, redirect_pc, fetch_pc;
    logic [15:0] mem_rdata, instr;

    cpu_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .fetch_pc(fetch_pc)
    );

    always #5 clk = ~clk;

    // ROM: word = 0x1000 + address, one cycle read latency
    always @(posedge clk) mem_rdata <= 16'h1000 + 16'(mem_addr);

    int n_chk = 0, n_pass = 0;
    int cyc = 0, first_cyc = -1;
    logic [7:0] mq[$];       // expected FIFO contents (PCs), head first
    logic [7:0] dq[$];       // PCs actually delivered by the DUT
    bit         m_inf = 1'b0, m_known = 1'b0;
    logic [7:0] m_infpc = '0, m_pc = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step(input bit r, input bit rdy, input bit h, input bit rv, input logic [7:0] rpc);
        bit exp_req;
        @(negedge clk);
        reset = r; instr_ready = rdy; halt = h; redirect_valid = rv; redirect_pc = rpc;
        #1;
        exp_req = !r && !h && !rv && (mq.size() + int'(m_inf) < 4);
        chk("mem_req", 32'(mem_req), 32'(exp_req));
        if (m_known) begin
            chk("fetch_pc", 32'(fetch_pc), 32'(m_pc));
            chk("mem_addr", 32'(mem_addr), 32'(m_pc));
            chk("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("instr_pc", 32'(instr_pc), 32'(mq[0]));
                chk("instr", 32'(instr), 32'(16'h1000 + 16'(mq[0])));
            end
        end
        if (!r && !rv && rdy && instr_valid) dq.push_back(instr_pc);
        if (!r && first_cyc < 0 && instr_valid === 1'b1) first_cyc = cyc;
        @(posedge clk);
        if (r) begin
            mq.delete(); m_inf = 1'b0; m_pc = '0; m_known = 1'b1; cyc = 0;
        end else begin
            cyc++;
            if (rv) begin
                mq.delete(); m_inf = 1'b0; m_pc = rpc;
            end else begin
                if (mq.size() != 0 && rdy) void'(mq.pop_front());
                if (m_inf) mq.push_back(m_infpc);
                m_inf = exp_req; m_infpc = m_pc;
                if (exp_req) m_pc = m_pc + 8'd1;
            end
        end
    endtask

    task automatic run(input int n, input bit rdy, input bit h);
        for (int i = 0; i < n; i++) step(1'b0, rdy, h, 1'b0, 8'h00);
    endtask

    initial begin
        reset = 1'b1; instr_ready = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        // 1: reset, then stream
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        #2;
        chk("rst_instr", 32'(instr), 32'h0);
        chk("rst_instr_pc", 32'(instr_pc), 32'h0);
        first_cyc = -1;
        run(12, 1'b1, 1'b0);
        chk("first_valid_cycle", 32'(first_cyc), 32'd2);

        // 2: backpressure then release
        run(10, 1'b0, 1'b0);
        run(12, 1'b1, 1'b0);

        // 3: redirect while stream is busy
        dq.delete();
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h40);
        run(8, 1'b1, 1'b0);
        chk("redir_delivered", 32'(dq.size() > 0), 32'd1);
        if (dq.size() > 0) chk("redir_first_pc", 32'(dq[0]), 32'h40);

        // 4: halt mid-stream
        run(6, 1'b1, 1'b1);
        chk("halt_drained", 32'(instr_valid), 32'd0);
        run(8, 1'b1, 1'b0);

        // 5: address wrap
        dq.delete();
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hFE);
        run(8, 1'b1, 1'b0);
        chk("wrap_len", 32'(dq.size() >= 4), 32'd1);
        if (dq.size() >= 4) begin
            chk("wrap0", 32'(dq[0]), 32'hFE);
            chk("wrap1", 32'(dq[1]), 32'hFF);
            chk("wrap2", 32'(dq[2]), 32'h00);
            chk("wrap3", 32'(dq[3]), 32'h01);
        end

        // 6: reset with full FIFO
        run(8, 1'b0, 1'b0);
        chk("full_before_reset", 32'(mq.size()), 32'd4);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        #2;
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_fetch_pc", 32'(fetch_pc), 32'd0);
        chk("midrst_instr_pc", 32'(instr_pc), 32'd0);
        dq.delete();
        run(6, 1'b1, 1'b0);
        if (dq.size() > 0) chk("midrst_first_pc", 32'(dq[0]), 32'h0);
        else chk("midrst_delivered", 32'(dq.size()), 32'd1);

        // 7: random mix
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 4, 8'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
